// File: rtl/booth_pkg.sv
// booth_pkg: shared state encoding and counter sizing for the Booth multiplier
package booth_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} booth_state_t;

    function automatic int booth_cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational radix-2 Booth iteration (add/sub then arithmetic shift)
module booth_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] i_a,
    input  logic [WIDTH:0] i_q,
    input  logic           i_q_1,
    input  logic [WIDTH:0] i_m,
    output logic [WIDTH:0] o_a,
    output logic [WIDTH:0] o_q,
    output logic           o_q_1
);

    logic [WIDTH:0] w_sum;

    // {Q[0],Q_1}=10 subtracts M, 01 adds M, otherwise A passes through
    always_comb begin
        w_sum = (i_q[0] & ~i_q_1) ? i_a - i_m : (~i_q[0] & i_q_1) ? i_a + i_m : i_a;
    end

    assign {o_a, o_q, o_q_1} = {w_sum[WIDTH], w_sum, i_q};

endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-2 Booth multiplier with valid/ready handshakes
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product
);

    localparam int CW = booth_cnt_w(WIDTH);

    booth_state_t   r_state;
    booth_state_t   w_next;
    logic [WIDTH:0] r_a;
    logic [WIDTH:0] r_q;
    logic [WIDTH:0] r_m;
    logic           r_q_1;
    logic [CW-1:0]  r_cnt;
    logic [WIDTH:0] w_a;
    logic [WIDTH:0] w_q;
    logic           w_q_1;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_q_1 (r_q_1),
        .i_m   (r_m),
        .o_a   (w_a),
        .o_q   (w_q),
        .o_q_1 (w_q_1)
    );

    // State register; reset overrides any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode: accept in IDLE, finish when the last step retires, release on out_ready
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid ? CALC : IDLE;
            CALC:    w_next = (r_cnt == CW'(1)) ? DONE : CALC;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are pure state decodes; the product is only exposed while DONE
    always_comb begin
        in_ready    = (r_state == IDLE);
        out_valid   = (r_state == DONE);
        out_product = (r_state == DONE) ? {r_a[WIDTH-2:0], r_q} : '0;
    end

    // Datapath: capture extended operands on acceptance, then one Booth step per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_q   <= '0;
            r_m   <= '0;
            r_q_1 <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_m   <= {in_signed & in_a[WIDTH-1], in_a};
            r_q   <= {in_signed & in_b[WIDTH-1], in_b};
            r_a   <= '0;
            r_q_1 <= 1'b0;
            r_cnt <= CW'(WIDTH + 1);
        end else if (r_state == CALC) begin
            r_a   <= w_a;
            r_q   <= w_q;
            r_q_1 <= w_q_1;
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier: scoreboard bench over WIDTH 2/4/8/16 instances
module tb_booth_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv   [4];
    logic        sg   [4];
    logic        ordy [4];
    logic [15:0] a_s  [4];
    logic [15:0] b_s  [4];
    logic        ir   [4];
    logic        ov   [4];
    logic [31:0] prod [4];
    logic [31:0] sb [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        localparam int W = 2 << g;
        logic [2*W-1:0] p;
        booth_seq_multiplier #(.WIDTH(W)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (iv[g]),
            .in_ready    (ir[g]),
            .in_a        (a_s[g][W-1:0]),
            .in_b        (b_s[g][W-1:0]),
            .in_signed   (sg[g]),
            .out_valid   (ov[g]),
            .out_ready   (ordy[g]),
            .out_product (p)
        );
        assign prod[g] = 32'(p);
    end

    function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b, input bit s);
        longint mask;
        longint x;
        longint y;
        longint pr;
        mask = (64'sd1 <<< w) - 1;
        x = longint'(a) & mask;
        y = longint'(b) & mask;
        if (s && x[w-1]) x = x - (64'sd1 <<< w);
        if (s && y[w-1]) y = y - (64'sd1 <<< w);
        pr = x * y;
        return 32'(pr & ((64'sd1 <<< (2 * w)) - 1));
    endfunction

    task automatic drive_op(input int g, input logic [15:0] a, input logic [15:0] b, input bit s,
                            input logic [31:0] e, output int acc);
        int n;
        n = 0;
        while (ir[g] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (ir[g] !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout: in_ready=%b required 1", ir[g]);
        end
        a_s[g] = a;
        b_s[g] = b;
        sg[g]  = s;
        iv[g]  = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        iv[g] = 1'b0;
        acc = cyc;
    endtask

    task automatic get_result(input int g, input string name, input int lat_exp);
        int lat;
        logic [31:0] e;
        lat = 0;
        while (ov[g] !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        if (lat_exp > 0) begin
            checks++;
            if (lat !== lat_exp) begin
                failures++;
                $display("FAIL %s_latency: got %0d cycles required %0d", name, lat, lat_exp);
            end
        end
        checks++;
        if (prod[g] !== e) begin
            failures++;
            $display("FAIL %s: product %h required %h", name, prod[g], e);
        end
        ordy[g] = 1'b1;
        @(posedge clk); #1;
        ordy[g] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (ir[g] !== 1'b1 || ov[g] !== 1'b0 || prod[g] !== 32'h0) begin
                failures++;
                $display("FAIL reset_w%0d: ready=%b valid=%b product=%h required 1 0 0", 2 << g, ir[g], ov[g], prod[g]);
            end
        end
    endtask

    task automatic test_directed();
        int acc;
        drive_op(1, 16'hD, 16'h5, 1'b1, 32'hF1, acc);
        get_result(1, "s_neg3x5", 5);
        drive_op(1, 16'hF, 16'hF, 1'b0, 32'hE1, acc);
        get_result(1, "u_15x15", 5);
        drive_op(1, 16'hF, 16'hF, 1'b1, 32'h01, acc);
        get_result(1, "s_m1xm1", 5);
        drive_op(1, 16'h8, 16'h8, 1'b1, 32'h40, acc);
        get_result(1, "s_m8xm8", 5);
        drive_op(1, 16'h8, 16'h7, 1'b1, 32'hC8, acc);
        get_result(1, "s_m8x7", 5);
        drive_op(2, 16'h80, 16'h80, 1'b1, 32'h4000, acc);
        get_result(2, "w8_min_sq", 9);
        drive_op(0, 16'h2, 16'h2, 1'b1, 32'h4, acc);
        get_result(0, "w2_min_sq", 3);
        drive_op(3, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, acc);
        get_result(3, "w16_umax_sq", 17);
    endtask

    task automatic test_backpressure();
        int acc;
        int n;
        logic [31:0] e;
        drive_op(1, 16'h6, 16'h7, 1'b1, 32'h2A, acc);
        n = 0;
        while (ov[1] !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            ordy[1] = 1'b0;
            iv[1]   = (i == 3);
            a_s[1]  = 16'h3;
            b_s[1]  = 16'h3;
            @(posedge clk); #1;
            checks++;
            if (ov[1] !== 1'b1 || prod[1] !== 32'h2A || ir[1] !== 1'b0) begin
                failures++;
                $display("FAIL stall_%0d: valid=%b product=%h ready=%b required 1 0000002a 0", i, ov[1], prod[1], ir[1]);
            end
        end
        iv[1] = 1'b0;
        e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        checks++;
        if (prod[1] !== e) begin
            failures++;
            $display("FAIL stall_result: product %h required %h", prod[1], e);
        end
        ordy[1] = 1'b1;
        @(posedge clk); #1;
        ordy[1] = 1'b0;
        checks++;
        if (ir[1] !== 1'b1 || ov[1] !== 1'b0) begin
            failures++;
            $display("FAIL release: ready=%b valid=%b required 1 0", ir[1], ov[1]);
        end
        @(posedge clk); #1;
        checks++;
        if (ir[1] !== 1'b1) begin
            failures++;
            $display("FAIL ignored_pulse: ready=%b required 1", ir[1]);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        bit seen;
        a_s[1] = 16'h5;
        b_s[1] = 16'h6;
        sg[1]  = 1'b1;
        iv[1]  = 1'b1;
        @(posedge clk); #1;
        iv[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (ir[1] !== 1'b1 || ov[1] !== 1'b0 || prod[1] !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset: ready=%b valid=%b product=%h required 1 0 0", ir[1], ov[1], prod[1]);
        end
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ov[1] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_no_valid: valid pulse seen=%b required 0", seen);
        end
        drive_op(1, 16'h3, 16'h3, 1'b1, 32'h09, acc);
        get_result(1, "after_reset_3x3", 5);
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        drive_op(1, 16'h2, 16'h3, 1'b0, 32'h06, acc1);
        get_result(1, "b2b_first", 5);
        drive_op(1, 16'hE, 16'h3, 1'b1, 32'hFA, acc2);
        get_result(1, "b2b_second", 5);
        checks++;
        if (acc2 - acc1 !== 7) begin
            failures++;
            $display("FAIL b2b_interval: got %0d cycles required 7", acc2 - acc1);
        end
    endtask

    task automatic test_random(input int g, input int n);
        int w;
        w = 2 << g;
        fork
            begin
                int acc;
                logic [15:0] a;
                logic [15:0] b;
                bit s;
                for (int i = 0; i < n; i++) begin
                    a = 16'($urandom);
                    b = 16'($urandom);
                    if (i == 0) a = 16'(1 << (w - 1));
                    if (i == 0) b = 16'(1 << (w - 1));
                    s = 1'($urandom_range(0, 1));
                    drive_op(g, a, b, s, model(w, a, b, s), acc);
                end
            end
            begin
                int got;
                int guard;
                logic [31:0] e;
                got = 0;
                guard = 0;
                while (got < n && guard < 5000) begin
                    ordy[g] = ($urandom_range(0, 3) != 0);
                    if (ov[g] === 1'b1 && ordy[g] === 1'b1) begin
                        e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
                        checks++;
                        if (prod[g] !== e) begin
                            failures++;
                            $display("FAIL rand_w%0d_%0d: product %h required %h", w, got, prod[g], e);
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    guard++;
                end
                ordy[g] = 1'b0;
                if (got < n) begin
                    checks++;
                    failures++;
                    $display("FAIL rand_w%0d_timeout: results %0d required %0d", w, got, n);
                end
            end
        join
    endtask

    initial begin
        for (int g = 0; g < 4; g++) begin
            iv[g]   = 1'b0;
            sg[g]   = 1'b0;
            ordy[g] = 1'b0;
            a_s[g]  = '0;
            b_s[g]  = '0;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        for (int g = 0; g < 4; g++) test_random(g, 40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
